// File: rtl/vector_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator_if
// Description : Handshake and data bundle for the vector accumulator.
//               The master starts runs and supplies beats; the slave
//               returns status and the per-lane results.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_accumulator_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) ();
  logic                   start;
  logic [CNT_W-1:0]       len;
  logic                   sat;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   busy;
  logic                   done;
  logic [LANES*ACC_W-1:0] acc_out;
  logic [LANES-1:0]       overflow;

  modport master (
    output start, len, sat, in_valid, in_data,
    input  in_ready, busy, done, acc_out, overflow
  );

  modport slave (
    input  start, len, sat, in_valid, in_data,
    output in_ready, busy, done, acc_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/vector_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator
// Description : LANES-wide accumulator. A run of len beats (0 = 2^CNT_W)
//               adds each lane's word into its own accumulator, with wrap
//               or saturate arithmetic and sticky per-lane overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_accumulator #(
  parameter int LANES = 8,
  parameter int WIDTH = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  wire logic            wrclk,
  input  wire logic            rst_n,
  vector_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   sat_q, sat_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   in_ready_q, in_ready_d;

  logic [LANES*ACC_W-1:0] w_lane_next;
  logic [LANES-1:0]       w_lane_carry;
  logic                   w_accept;
  logic [CNT_W-1:0]       w_last_cnt;

  // in_ready_q is only ever high in RUN, so it alone qualifies a beat
  assign w_accept   = bus.in_valid & in_ready_q;
  // len of 0 wraps to the all-ones count, giving a full 2^CNT_W-beat run
  assign w_last_cnt = len_q - CNT_ONE;

  // Per-lane sum one bit wider than the accumulator; the top bit is the carry
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W:0] w_word;
    logic [ACC_W:0] w_sum;
    assign w_word = {{(ACC_W+1-WIDTH){1'b0}}, bus.in_data[i*WIDTH +: WIDTH]};
    assign w_sum  = {1'b0, acc_q[i*ACC_W +: ACC_W]} + w_word;
    assign w_lane_carry[i] = w_sum[ACC_W];
    assign w_lane_next[i*ACC_W +: ACC_W] =
      (w_sum[ACC_W] && sat_q) ? ACC_MAX : w_sum[ACC_W-1:0];
  end

  // Next-state and next-datapath computation for the run sequencer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = '0;
          cnt_d   = '0;
          len_d   = bus.len;
          sat_d   = bus.sat;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_accept) begin
          acc_d = w_lane_next;
          ovf_d = ovf_q | w_lane_carry;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == w_last_cnt) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status outputs are registered versions of the upcoming state
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    in_ready_d = (state_d == RUN);
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_out  = acc_q;
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire
